can_tx_scheduler: RTL

Transmit scheduler for the CAN core. It chooses between the TX high-priority buffer (HPB) and the TX FIFO and latches the chosen 128-bit message, packed as {id, dlc, dataword1, dataword2}. It then holds a request to the bit-stream processor (BSP) until that message finishes. Based on the BSP outcome it retires the message, retries it or drops it.

---
 rtl/can_tx_pkg.sv | 34 +++
 rtl/can_tx_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/can_tx_pkg.sv
// Shared definitions for the CAN transmit scheduler: FSM encodings, message field
// slices, source encodings and retry counter width.
package can_tx_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] POP  = 2'd2;

   localparam int ID_MSB  = 127;
   localparam int ID_LSB  = 96;
   localparam int DLC_MSB = 95;
   localparam int DLC_LSB = 64;
   localparam int DW1_MSB = 63;
   localparam int DW1_LSB = 32;
   localparam int DW2_MSB = 31;
   localparam int DW2_LSB = 0;

   localparam logic SRC_HPB  = 1'b1;
   localparam logic SRC_FIFO = 1'b0;

   localparam int RETRY_W = 4;

   function automatic logic [127:0] pack_msg(input logic [31:0] id, input logic [31:0] dlc,
                                             input logic [31:0] dw1, input logic [31:0] dw2);
      logic [127:0] m;
      m                  = 128'd0;
      m[ID_MSB:ID_LSB]   = id;
      m[DLC_MSB:DLC_LSB] = dlc;
      m[DW1_MSB:DW1_LSB] = dw1;
      m[DW2_MSB:DW2_LSB] = dw2;
      return m;
   endfunction

endpackage

// File: rtl/can_tx_scheduler.sv
// Picks HPB over FIFO, holds a request to the BSP until the frame outcome arrives,
// then retires, retries or drops the message. All outputs come straight from flops.
module can_tx_scheduler
   import can_tx_pkg::*;
#(
   parameter int unsigned MAX_RETRY = 8
)
(
   input  logic           sys_clk,
   input  logic           IP2Can_reset_n,
   input  logic [127:0]   txfifo_ip,
   input  logic           txfifo_empty,
   input  logic [127:0]   txhpb_ip,
   input  logic           txhpb_full,
   input  logic           bsp_tx_done,
   input  logic           bsp_arb_lost,
   input  logic           bsp_tx_err,
   output logic [127:0]   tx_msg,
   output logic           tx_req,
   output logic           tx_src,
   output logic           txfifo_rd_en,
   output logic           txhpb_clr,
   output logic           tx_ok,
   output logic           tx_abort,
   output logic [3:0]     retry_cnt
);

   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

   logic [1:0]         state_q, state_d;
   logic [127:0]       msg_q, msg_d;
   logic               src_q, src_d;
   logic               req_q, req_d;
   logic               pend_abort_q, pend_abort_d;
   logic               rd_en_q, rd_en_d;
   logic               clr_q, clr_d;
   logic               ok_q, ok_d;
   logic               abort_q, abort_d;
   logic [RETRY_W-1:0] retry_q, retry_d;

   // Next-state, latch and pulse computation
   always_comb begin
      state_d      = state_q;
      msg_d        = msg_q;
      src_d        = src_q;
      pend_abort_d = pend_abort_q;
      retry_d      = retry_q;
      // tx_req trails the REQ state by one cycle, so it falls one edge after the outcome
      req_d        = (state_q == REQ);
      rd_en_d      = (state_q == POP) && (src_q == SRC_FIFO);
      clr_d        = (state_q == POP) && (src_q == SRC_HPB);
      ok_d         = (state_q == POP) && !pend_abort_q;
      abort_d      = (state_q == POP) && pend_abort_q;

      case (state_q)
         IDLE: begin
            if (txhpb_full) begin
               msg_d   = txhpb_ip;
               src_d   = SRC_HPB;
               state_d = REQ;
               if (src_q != SRC_HPB) begin
                  retry_d = 4'd0;
               end else begin
                  retry_d = retry_q;
               end
            end else if (!txfifo_empty) begin
               msg_d   = txfifo_ip;
               src_d   = SRC_FIFO;
               state_d = REQ;
               if (src_q != SRC_FIFO) begin
                  retry_d = 4'd0;
               end else begin
                  retry_d = retry_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (bsp_tx_done) begin
               pend_abort_d = 1'b0;
               state_d      = POP;
            end else if (bsp_tx_err) begin
               if (retry_q == RETRY_LAST) begin
                  pend_abort_d = 1'b1;
                  state_d      = POP;
               end else begin
                  retry_d = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 4'd1;
                  state_d = IDLE;
               end
            end else if (bsp_arb_lost) begin
               state_d = IDLE;
            end else begin
               state_d = REQ;
            end
         end
         POP: begin
            retry_d = 4'd0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge sys_clk or negedge IP2Can_reset_n) begin
      if (!IP2Can_reset_n) begin
         state_q      <= IDLE;
         msg_q        <= 128'd0;
         src_q        <= SRC_FIFO;
         req_q        <= 1'b0;
         pend_abort_q <= 1'b0;
         rd_en_q      <= 1'b0;
         clr_q        <= 1'b0;
         ok_q         <= 1'b0;
         abort_q      <= 1'b0;
         retry_q      <= 4'd0;
      end else begin
         state_q      <= state_d;
         msg_q        <= msg_d;
         src_q        <= src_d;
         req_q        <= req_d;
         pend_abort_q <= pend_abort_d;
         rd_en_q      <= rd_en_d;
         clr_q        <= clr_d;
         ok_q         <= ok_d;
         abort_q      <= abort_d;
         retry_q      <= retry_d;
      end
   end

   assign tx_msg       = msg_q;
   assign tx_req       = req_q;
   assign tx_src       = src_q;
   assign txfifo_rd_en = rd_en_q;
   assign txhpb_clr    = clr_q;
   assign tx_ok        = ok_q;
   assign tx_abort     = abort_q;
   assign retry_cnt    = retry_q;

endmodule
